sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO with binary pointers, an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. A mode parameter selects registered-read mode or first-word-fall-through mode. It is the single-domain successor to the dual-clock gray-pointer FIFO. It buffers data between producers and consumers that share `clk`, where a CDC pointer scheme is unnecessary.

Parameters:
datawidth, 8, data word width in bits
addr_width, 3, address width; DEPTH = 2**addr_width entries
afull_thresh, 6, walmost_full asserts when count >= afull_thresh (legal range 1..DEPTH)
aempty_thresh, 1, ralmost_empty asserts when count <= aempty_thresh (legal range 0..DEPTH-1)
fwft, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
wdata  input  datawidth  write data
winc  input  1  write request
rinc  input  1  read request (pop)
rdata  output  datawidth  read data
wfull  output  1  FIFO holds DEPTH entries
rempty  output  1  FIFO holds 0 entries
walmost_full  output  1  count >= afull_thresh
ralmost_empty  output  1  count <= aempty_thresh
count  output  addr_width+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `rst`.
- Pointers:
  - wptr and rptr are addr_width+1-bit binary registers.
  - Memory is addressed by the low addr_width bits.
  - MSB toggles on each wrap.
- Status flags, decoded combinationally from registered state:
  - count = wptr - rptr (mod 2**(addr_width+1)).
  - rempty = (wptr == rptr).
  - wfull = MSBs differ and low bits equal.
  - walmost_full and ralmost_empty are decoded from count.
  - All flags therefore reflect the state after the most recent edge.
- Write accept: wen = winc & ~wfull. On wen: mem[wptr low bits] <= wdata and wptr increments.
- Read accept: ren = rinc & ~rempty. On ren, rptr increments.
- Accept decisions use the flags valid at the start of the cycle:
  - Simultaneous winc & rinc while empty: write accepted, read rejected.
  - Simultaneous winc & rinc while full: read accepted, write rejected.
  - Otherwise both are accepted and count is unchanged.
- fwft=0 read path:
  - On ren, the rdata register loads mem[rptr] and is valid on the following cycle (latency 1).
  - rdata holds its value when there is no ren.
- fwft=1 read path:
  - rdata = mem[rptr low bits] combinationally whenever rempty=0; rinc pops the word.
  - When rempty=1, rdata holds its last registered value; implement with a head register updated on pop/write.
  - A word written into an empty FIFO appears on rdata the cycle after the write edge, together with rempty deasserting.
- Write-to-read visibility: a write at edge N makes rempty=0 after edge N. A read of that word is accepted at edge N+1 at the earliest.
- Sticky error flags:
  - overflow sets on (winc & wfull); underflow sets on (rinc & rempty).
  - Both remain set until rst; they do not block further operation.
- Wrap-around: pointers wrap modulo 2**(addr_width+1) with no special handling. Ordering is preserved across any number of wraps.
- Reset values:
  - wptr=0, rptr=0, count=0, rempty=1, wfull=0.
  - walmost_full=0, ralmost_empty=1.
  - overflow=0, underflow=0, rdata=0.
  - Memory contents are not reset.
- Reset mid-operation: rst wins over winc/rinc in the same cycle. The request is discarded and no flag is set. Stored data becomes unreachable.
- Implementation is 120-400 lines of RTL: register-array memory, pointer logic, flag decode, fwft mux.

Test Plan:
- Reset: rst=1 for 2 cycles with winc=rinc=1 -> count=0, rempty=1, wfull=0, ralmost_empty=1, overflow=underflow=0, rdata=0.
- Fill, fwft=0, DEPTH=8: write 0x01..0x08 -> walmost_full rises after the 6th write, wfull=1 after the 8th, count=8. A 9th write of 0xFF -> rejected, overflow=1. Then 8 reads -> rdata 0x01..0x08, each one cycle after its rinc. A 9th read -> underflow=1, rdata stays 0x08.
- Simultaneous read/write: at count=4, hold winc=rinc=1 for 20 cycles with incrementing data -> count stays 4, output order strictly sequential, no error flags. When empty, winc=rinc=1 -> count=1, underflow=1.
- Wrap-around: 3 full fill/drain passes (24 words) with random data -> scoreboard matches exactly, pointer MSB toggles 3 times.
- fwft=1: write 0xA5 into empty -> next cycle rempty=0 and rdata=0xA5 with no rinc. Pop -> rempty=1.
- Reset mid-operation: at count=5 assert rst with winc=1 -> next cycle count=0, rempty=1. Data written afterwards reads back first.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty and sticky error flags.
// Latency: fwft=0 -> rdata valid the cycle after an accepted pop; fwft=1 -> head word shown combinationally.
// Backpressure: writes are dropped while wfull and reads while rempty; each attempt sets a sticky error flag.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   wdata, winc       - write data and write request
//   rinc, rdata       - read request (pop) and read data
//   wfull, rempty     - FIFO holds DEPTH / 0 entries
//   walmost_full      - count >= afull_thresh
//   ralmost_empty     - count <= aempty_thresh
//   count             - current occupancy, 0..DEPTH
//   overflow          - sticky: write attempted while full
//   underflow         - sticky: read attempted while empty
module sync_fifo_flags #(
   parameter int datawidth     = 8,
   parameter int addr_width    = 3,
   parameter int afull_thresh  = 6,
   parameter int aempty_thresh = 1,
   parameter int fwft          = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [datawidth-1:0]  wdata,
   input  logic                  winc,
   input  logic                  rinc,
   output logic [datawidth-1:0]  rdata,
   output logic                  wfull,
   output logic                  rempty,
   output logic                  walmost_full,
   output logic                  ralmost_empty,
   output logic [addr_width:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int depth = 1 << addr_width;

   // Thresholds sized to the count width so the compares are width-matched.
   localparam logic [addr_width:0] afull_lv  = (addr_width+1)'(afull_thresh);
   localparam logic [addr_width:0] aempty_lv = (addr_width+1)'(aempty_thresh);

   // Pointers carry one extra MSB that toggles on every wrap; it is what
   // distinguishes full from empty when the low address bits match.
   logic [addr_width:0]   wptr;
   logic [addr_width:0]   rptr;
   logic [datawidth-1:0]  mem [depth];
   logic [datawidth-1:0]  rdata_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  wen;
   logic                  ren;

   logic [addr_width-1:0] waddr;
   logic [addr_width-1:0] raddr;

   assign waddr = wptr[addr_width-1:0];
   assign raddr = rptr[addr_width-1:0];

   // ---------------------------------------------------------------
   // Status decode, purely from registered pointers
   // ---------------------------------------------------------------
   assign count         = wptr - rptr;
   assign rempty        = (wptr == rptr);
   assign wfull         = (wptr[addr_width] != rptr[addr_width]) && (waddr == raddr);
   assign walmost_full  = (count >= afull_lv);
   assign ralmost_empty = (count <= aempty_lv);

   // Accept decisions use start-of-cycle flags: a write into an empty FIFO
   // cannot be read in the same cycle, and a read from a full FIFO does not
   // free a slot for a write in the same cycle.
   assign wen = winc & ~wfull;
   assign ren = rinc & ~rempty;

   // ---------------------------------------------------------------
   // Pointers, read register and sticky errors
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr        <= '0;
         rptr        <= '0;
         rdata_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wen) begin
            wptr <= wptr + 1'b1;
         end
         if (ren) begin
            rptr    <= rptr + 1'b1;
            // In fwft mode this keeps the last popped word on rdata once the
            // FIFO runs empty; in registered mode it is the read data itself.
            rdata_q <= mem[raddr];
         end
         if (winc && wfull) begin
            overflow_q <= 1'b1;
         end
         if (rinc && rempty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   // Storage is not reset; a write coinciding with rst is discarded.
   always_ff @(posedge clk) begin
      if (!rst && wen) begin
         mem[waddr] <= wdata;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // ---------------------------------------------------------------
   // Read data path
   // ---------------------------------------------------------------
   generate
      if (fwft != 0) begin : g_fwft
         // Head word shown as soon as the FIFO is non-empty.
         assign rdata = rempty ? rdata_q : mem[raddr];
      end else begin : g_reg
         assign rdata = rdata_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one registered-read instance and one fwft instance.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Both instances share clock and reset; the fwft instance is idle outside its own test.
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst;

   logic [7:0] wdata0, rdata0;
   logic       winc0, rinc0, wfull0, rempty0, afull0, aempty0, ovf0, unf0;
   logic [3:0] count0;

   logic [7:0] wdata1, rdata1;
   logic       winc1, rinc1, wfull1, rempty1, afull1, aempty1, ovf1, unf1;
   logic [3:0] count1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sync_fifo_flags #(.datawidth(8), .addr_width(3), .afull_thresh(6),
                     .aempty_thresh(1), .fwft(0)) dut0 (
      .clk(clk), .rst(rst), .wdata(wdata0), .winc(winc0), .rinc(rinc0),
      .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .walmost_full(afull0),
      .ralmost_empty(aempty0), .count(count0), .overflow(ovf0), .underflow(unf0));

   sync_fifo_flags #(.datawidth(8), .addr_width(3), .afull_thresh(6),
                     .aempty_thresh(1), .fwft(1)) dut1 (
      .clk(clk), .rst(rst), .wdata(wdata1), .winc(winc1), .rinc(rinc1),
      .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .walmost_full(afull1),
      .ralmost_empty(aempty1), .count(count1), .overflow(ovf1), .underflow(unf1));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   logic [7:0] sb[$];
   logic [7:0] v;
   logic [7:0] e;

   initial begin
      rst = 1'b1;
      wdata0 = 8'h33; winc0 = 1'b1; rinc0 = 1'b1;
      wdata1 = 8'h33; winc1 = 1'b1; rinc1 = 1'b1;

      // Reset held two cycles with requests active
      step(); step();
      check("rst_count",  32'(count0), 32'd0);
      check("rst_rempty", 32'(rempty0), 32'd1);
      check("rst_wfull",  32'(wfull0), 32'd0);
      check("rst_afull",  32'(afull0), 32'd0);
      check("rst_aempty", 32'(aempty0), 32'd1);
      check("rst_ovf",    32'(ovf0), 32'd0);
      check("rst_unf",    32'(unf0), 32'd0);
      check("rst_rdata",  32'(rdata0), 32'd0);
      check("rst_rdata1", 32'(rdata1), 32'd0);
      check("rst_rempty1", 32'(rempty1), 32'd1);
      rst = 1'b0;
      winc0 = 1'b0; rinc0 = 1'b0; winc1 = 1'b0; rinc1 = 1'b0;

      // fwft: word appears without rinc the cycle after the write
      wdata1 = 8'hA5; winc1 = 1'b1; step(); winc1 = 1'b0;
      check("fwft_rempty_after_wr", 32'(rempty1), 32'd0);
      check("fwft_rdata_show",      32'(rdata1), 32'hA5);
      rinc1 = 1'b1; step(); rinc1 = 1'b0;
      check("fwft_rempty_after_pop", 32'(rempty1), 32'd1);
      check("fwft_rdata_hold",       32'(rdata1), 32'hA5);
      wdata1 = 8'h11; winc1 = 1'b1; step();
      wdata1 = 8'h22; step(); winc1 = 1'b0;
      check("fwft_head1", 32'(rdata1), 32'h11);
      rinc1 = 1'b1; step(); rinc1 = 1'b0;
      check("fwft_head2", 32'(rdata1), 32'h22);
      check("fwft_count", 32'(count1), 32'd1);

      // Fill 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         wdata0 = 8'(i); winc0 = 1'b1; step();
         check("fill_count", 32'(count0), 32'(i));
         check("fill_afull", 32'(afull0), 32'(i >= 6));
         check("fill_wfull", 32'(wfull0), 32'(i == 8));
      end
      wdata0 = 8'hFF; step(); winc0 = 1'b0;
      check("ovf_set",    32'(ovf0), 32'd1);
      check("ovf_count",  32'(count0), 32'd8);
      check("rdata_idle", 32'(rdata0), 32'd0);

      // Drain 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         rinc0 = 1'b1; step();
         check("drain_rdata",  32'(rdata0), 32'(i));
         check("drain_count",  32'(count0), 32'(8 - i));
         check("drain_aempty", 32'(aempty0), 32'((8 - i) <= 1));
      end
      step(); rinc0 = 1'b0;
      check("unf_set",    32'(unf0), 32'd1);
      check("unf_rdata",  32'(rdata0), 32'h08);
      check("unf_rempty", 32'(rempty0), 32'd1);

      // Simultaneous read/write at count=4
      do_reset();
      check("rst_clear_ovf", 32'(ovf0), 32'd0);
      check("rst_clear_unf", 32'(unf0), 32'd0);
      for (int i = 0; i < 4; i++) begin
         wdata0 = 8'(8'h10 + i); winc0 = 1'b1; step();
      end
      for (int k = 0; k < 20; k++) begin
         wdata0 = 8'(8'h14 + k); winc0 = 1'b1; rinc0 = 1'b1; step();
         check("rw_count", 32'(count0), 32'd4);
         check("rw_rdata", 32'(rdata0), 32'(8'h10 + k));
      end
      winc0 = 1'b0;
      check("rw_no_ovf", 32'(ovf0), 32'd0);
      check("rw_no_unf", 32'(unf0), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("rw_drain", 32'(rdata0), 32'(8'h24 + i));
      end
      // Empty with both requests: write wins, read rejected
      wdata0 = 8'h55; winc0 = 1'b1; rinc0 = 1'b1; step();
      winc0 = 1'b0; rinc0 = 1'b0;
      check("empty_rw_count", 32'(count0), 32'd1);
      check("empty_rw_unf",   32'(unf0), 32'd1);
      check("empty_rw_rdata", 32'(rdata0), 32'h27);
      rinc0 = 1'b1; step(); rinc0 = 1'b0;
      check("empty_rw_read",  32'(rdata0), 32'h55);

      // Three full fill/drain passes from reset: pointer MSB wraps three times
      do_reset();
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 8; i++) begin
            v = 8'($urandom_range(0, 255));
            sb.push_back(v);
            wdata0 = v; winc0 = 1'b1; step();
         end
         winc0 = 1'b0;
         check("wrap_full", 32'(wfull0), 32'd1);
         for (int i = 0; i < 8; i++) begin
            rinc0 = 1'b1; step();
            e = sb.pop_front();
            check("wrap_rdata", 32'(rdata0), 32'(e));
         end
         rinc0 = 1'b0;
         check("wrap_empty", 32'(rempty0), 32'd1);
      end
      check("wrap_no_ovf", 32'(ovf0), 32'd0);
      check("wrap_no_unf", 32'(unf0), 32'd0);

      // Reset mid-operation at count=5 with a write pending
      for (int i = 0; i < 5; i++) begin
         wdata0 = 8'(8'h61 + i); winc0 = 1'b1; step();
      end
      check("mid_pre_count", 32'(count0), 32'd5);
      rst = 1'b1; wdata0 = 8'hEE; step();
      rst = 1'b0; winc0 = 1'b0;
      check("mid_count",  32'(count0), 32'd0);
      check("mid_rempty", 32'(rempty0), 32'd1);
      check("mid_ovf",    32'(ovf0), 32'd0);
      check("mid_rdata",  32'(rdata0), 32'd0);
      wdata0 = 8'h77; winc0 = 1'b1; step(); winc0 = 1'b0;
      rinc0 = 1'b1; step(); rinc0 = 1'b0;
      check("mid_readback", 32'(rdata0), 32'h77);
      check("mid_final_empty", 32'(rempty0), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
